// File: rtl/mul_bfloat16_out_stage.sv
// rtl/mul_bfloat16_out_stage.sv - registered skid-buffered output stage for the bfloat16 multiplier
//
// Captures the multiplier result word and 8-bit status under a valid/ready
// handshake. It uses a two-entry (main + skid) buffer, so in_ready can come
// straight from a flop and the stage still moves one item per cycle. It also
// keeps sticky exception flags and a wrap-around delivered-result counter.
//
// Optional feature: define MUL_BF16_OUT_STAGE_CANON_NAN_EN to replace any NaN
// result with the canonical quiet NaN as it is captured.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   in_valid/in_ready   upstream handshake (in_ready is a flop output)
//   in_o, in_status     multiplier result word and status (DW bit order)
//   out_valid/out_ready downstream handshake
//   out_data/out_status registered result and its status
//   flags_sticky        OR of in_status over accepted items since reset/clear
//   flags_clr           single-cycle clear of flags_sticky
//   res_cnt             delivered-result count, modulo 2^CNT_W
module mul_bfloat16_out_stage #(
    parameter int N_SIG  = 7,
    parameter int N_EXP  = 8,
    parameter int N_DATA = N_EXP + N_SIG + 1,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [N_DATA-1:0] in_o,
    input  logic [7:0]        in_status,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [N_DATA-1:0] out_data,
    output logic [7:0]        out_status,
    output logic [7:0]        flags_sticky,
    input  logic              flags_clr,
    output logic [CNT_W-1:0]  res_cnt
);

    typedef enum logic [1:0] {S_EMPTY, S_ONE, S_FULL} state_t;

    state_t             state_q, state_d;
    logic               in_ready_q, in_ready_d;
    logic               out_valid_q, out_valid_d;
    logic [N_DATA-1:0]  main_data_q, main_data_d;
    logic [7:0]         main_status_q, main_status_d;
    logic [N_DATA-1:0]  skid_data_q, skid_data_d;
    logic [7:0]         skid_status_q, skid_status_d;
    logic [7:0]         flags_q, flags_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic               accept;
    logic               deliver;
    logic [N_DATA-1:0]  in_data_c;

    assign accept  = in_valid && in_ready_q;
    assign deliver = out_valid_q && out_ready;

`ifdef MUL_BF16_OUT_STAGE_CANON_NAN_EN
    localparam logic [N_DATA-1:0] CANON_NAN =
        {1'b0, {N_EXP{1'b1}}, 1'b1, {(N_SIG-1){1'b0}}};
    logic is_nan;
    // NaN: exponent all ones and a nonzero significand (infinity is left alone).
    assign is_nan    = (&in_o[N_DATA-2 -: N_EXP]) && (|in_o[N_SIG-1:0]);
    assign in_data_c = is_nan ? CANON_NAN : in_o;
`else
    assign in_data_c = in_o;
`endif

    always_comb begin
        state_d       = state_q;
        main_data_d   = main_data_q;
        main_status_d = main_status_q;
        skid_data_d   = skid_data_q;
        skid_status_d = skid_status_q;
        case (state_q)
            S_EMPTY: begin
                if (accept) begin
                    main_data_d   = in_data_c;
                    main_status_d = in_status;
                    state_d       = S_ONE;
                end
            end
            S_ONE: begin
                if (accept && deliver) begin
                    main_data_d   = in_data_c;
                    main_status_d = in_status;
                end else if (accept) begin
                    // Consumer stalled: park the new item behind the head.
                    skid_data_d   = in_data_c;
                    skid_status_d = in_status;
                    state_d       = S_FULL;
                end else if (deliver) begin
                    state_d = S_EMPTY;
                end
            end
            S_FULL: begin
                // in_ready is low here, so only a deliver can happen.
                if (deliver) begin
                    main_data_d   = skid_data_q;
                    main_status_d = skid_status_q;
                    state_d       = S_ONE;
                end
            end
            default: state_d = S_EMPTY;
        endcase

        // Handshake outputs are precomputed from the next state so they are flops.
        out_valid_d = (state_d != S_EMPTY);
        in_ready_d  = (state_d != S_FULL);

        // A clear coinciding with an accept keeps the new item's status.
        flags_d = (flags_clr ? 8'h00 : flags_q) | (accept ? in_status : 8'h00);
        cnt_d   = cnt_q + CNT_W'(deliver);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_EMPTY;
            in_ready_q    <= 1'b1;
            out_valid_q   <= 1'b0;
            main_data_q   <= '0;
            main_status_q <= '0;
            skid_data_q   <= '0;
            skid_status_q <= '0;
            flags_q       <= '0;
            cnt_q         <= '0;
        end else begin
            state_q       <= state_d;
            in_ready_q    <= in_ready_d;
            out_valid_q   <= out_valid_d;
            main_data_q   <= main_data_d;
            main_status_q <= main_status_d;
            skid_data_q   <= skid_data_d;
            skid_status_q <= skid_status_d;
            flags_q       <= flags_d;
            cnt_q         <= cnt_d;
        end
    end

    assign in_ready     = in_ready_q;
    assign out_valid    = out_valid_q;
    assign out_data     = main_data_q;
    assign out_status   = main_status_q;
    assign flags_sticky = flags_q;
    assign res_cnt      = cnt_q;

endmodule

// File: tb/tb_mul_bfloat16_out_stage.sv
// tb/tb_mul_bfloat16_out_stage.sv - self-checking bench for mul_bfloat16_out_stage
module tb_mul_bfloat16_out_stage;

    localparam int CNT_W = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [15:0]       in_o;
    logic [7:0]        in_status;
    logic              out_valid;
    logic              out_ready;
    logic [15:0]       out_data;
    logic [7:0]        out_status;
    logic [7:0]        flags_sticky;
    logic              flags_clr;
    logic [CNT_W-1:0]  res_cnt;

    always #5 clk = ~clk;

    mul_bfloat16_out_stage #(.CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_o         (in_o),
        .in_status    (in_status),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_status   (out_status),
        .flags_sticky (flags_sticky),
        .flags_clr    (flags_clr),
        .res_cnt      (res_cnt)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: a FIFO of at most two {data, status} items.
    logic [23:0]      q[$];
    logic [7:0]       m_flags;
    logic [CNT_W-1:0] m_cnt;

    function automatic logic [15:0] canon(input logic [15:0] d);
`ifdef MUL_BF16_OUT_STAGE_CANON_NAN_EN
        if (d[14:7] == 8'hFF && d[6:0] != 7'd0) return 16'h7FC0;
`endif
        return d;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_all();
        check("out_valid", out_valid, q.size() > 0);
        check("in_ready", in_ready, q.size() < 2);
        if (q.size() > 0) begin
            check("out_data", out_data, q[0][23:8]);
            check("out_status", out_status, q[0][7:0]);
        end
        check("flags_sticky", flags_sticky, m_flags);
        check("res_cnt", res_cnt, m_cnt);
    endtask

    // One clock cycle: drive inputs, advance, update the model, check at negedge.
    task automatic cyc(input logic v, input logic [15:0] d, input logic [7:0] s,
                       input logic ordy, input logic clr, input logic r);
        logic acc, del;
        in_valid  = v;
        in_o      = d;
        in_status = s;
        out_ready = ordy;
        flags_clr = clr;
        rst       = r;
        acc = !r && v && (q.size() < 2);
        del = !r && ordy && (q.size() > 0);
        @(posedge clk);
        #1;
        if (r) begin
            q.delete();
            m_flags = 8'h00;
            m_cnt   = '0;
        end else begin
            if (del) begin
                void'(q.pop_front());
                m_cnt = m_cnt + 1'b1;
            end
            if (acc) q.push_back({canon(d), s});
            if (clr) m_flags = acc ? s : 8'h00;
            else if (acc) m_flags = m_flags | s;
        end
        @(negedge clk);
        check_all();
    endtask

    typedef struct {
        logic [15:0] d;
        logic [7:0]  s;
        logic [15:0] exp_d;
    } vec_t;

    vec_t tbl[6];

    initial begin
        int idx;
        m_flags = 8'h00;
        m_cnt   = '0;

        tbl[0] = '{16'h3FC0, 8'h00, 16'h3FC0};
        tbl[1] = '{16'h7F80, 8'h02, 16'h7F80};
        tbl[2] = '{16'h0001, 8'h01, 16'h0001};
`ifdef MUL_BF16_OUT_STAGE_CANON_NAN_EN
        tbl[3] = '{16'hFF81, 8'h04, 16'h7FC0};
        tbl[4] = '{16'h7FC1, 8'h04, 16'h7FC0};
        tbl[5] = '{16'hFFFF, 8'h84, 16'h7FC0};
`else
        tbl[3] = '{16'hFF81, 8'h04, 16'hFF81};
        tbl[4] = '{16'h7FC1, 8'h04, 16'h7FC1};
        tbl[5] = '{16'hFFFF, 8'h84, 16'hFFFF};
`endif

        // Reset state
        cyc(0, 16'h0, 8'h0, 0, 0, 1);
        check("reset_out_data", out_data, 16'h0000);
        check("reset_out_status", out_status, 8'h00);

        // Single item: visible one edge later, counted when delivered
        cyc(1, 16'h3FC0, 8'h00, 1, 0, 0);
        check("single_valid", out_valid, 1'b1);
        check("single_data", out_data, 16'h3FC0);
        cyc(0, 16'h0, 8'h0, 1, 0, 0);
        check("single_cnt", res_cnt, 4'd1);

        // Table: pass-through / NaN handling
        for (int i = 0; i < 6; i++) begin
            cyc(1, tbl[i].d, tbl[i].s, 1, 0, 0);
            check("tbl_data", out_data, tbl[i].exp_d);
            check("tbl_status", out_status, tbl[i].s);
            cyc(0, 16'h0, 8'h0, 1, 0, 0);
        end

        // Backpressure: stream 1..4, consumer stalled for 4 cycles
        cyc(0, 16'h0, 8'h0, 0, 0, 1);
        idx = 1;
        for (int c = 0; c < 12; c++) begin
            logic will_acc;
            will_acc = (idx <= 4) && (q.size() < 2);
            cyc(idx <= 4, 16'(idx), 8'h00, c >= 4, 0, 0);
            if (c == 1) check("bp_in_ready_low", in_ready, 1'b0);
            if (c == 3) check("bp_held_data", out_data, 16'h0001);
            if (will_acc) idx++;
        end
        check("bp_all_accepted", idx, 5);
        check("bp_delivered", res_cnt, 4'd4);

        // Sticky flags, including clear with simultaneous accept
        cyc(0, 16'h0, 8'h0, 0, 0, 1);
        cyc(1, 16'h1111, 8'h20, 1, 0, 0);
        cyc(1, 16'h2222, 8'h10, 1, 0, 0);
        check("sticky_or", flags_sticky, 8'h30);
        cyc(1, 16'h3333, 8'h04, 1, 1, 0);
        check("sticky_clr_acc", flags_sticky, 8'h04);
        cyc(0, 16'h0, 8'h0, 1, 1, 0);
        check("sticky_clr", flags_sticky, 8'h00);

        // Counter wrap: 17 delivers at CNT_W=4
        cyc(0, 16'h0, 8'h0, 0, 0, 1);
        for (int i = 0; i < 17; i++) cyc(1, 16'(i + 16'h100), 8'h00, 1, 0, 0);
        cyc(0, 16'h0, 8'h0, 1, 0, 0);
        check("cnt_wrap", res_cnt, 4'd1);

        // Reset while FULL (flags_clr asserted too: reset wins)
        cyc(0, 16'h0, 8'h0, 0, 0, 1);
        cyc(1, 16'h0011, 8'h01, 0, 0, 0);
        cyc(1, 16'h0022, 8'h02, 1, 0, 0);
        cyc(1, 16'h0033, 8'h08, 0, 0, 0);
        check("full_in_ready", in_ready, 1'b0);
        cyc(1, 16'h0044, 8'h40, 1, 1, 1);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_flags", flags_sticky, 8'h00);
        check("rst_cnt", res_cnt, 4'd0);
        check("rst_data", out_data, 16'h0000);

        // Randomized traffic against the queue model
        for (int i = 0; i < 500; i++) begin
            logic [15:0] d;
            d = 16'($urandom);
            if ($urandom_range(0, 3) == 0) d[14:7] = 8'hFF;
            cyc($urandom_range(0, 2) != 0, d, 8'($urandom),
                $urandom_range(0, 2) != 0, $urandom_range(0, 7) == 0,
                $urandom_range(0, 63) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
